// File: rtl/shift_seq_ctrl.sv
// Word-to-serial sequencer: parallel word in, one bit per clk through a DEPTH-stage delay line.
// Latency: bit i appears on ser_q i+DEPTH cycles after the accept edge; done marks the last bit.
// Backpressure: in_ready is high only in IDLE, so there is one word in flight; flush aborts it.
// Build option: define MSB_FIRST_EN to emit in_data[WIDTH-1] first (default emits in_data[0] first).
module shift_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             ser_q,
  output logic             ser_en,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;

  // One bit per stage; index DEPTH-1 is the stage that drives the outputs.
  logic [DEPTH-1:0] d_chain;
  logic [DEPTH-1:0] v_chain;
  logic [DEPTH-1:0] l_chain;

  logic push_v;
  logic push_d;
  logic push_l;
  logic out_done;
  logic cur_bit;

`ifdef MSB_FIRST_EN
  assign cur_bit = shreg[WIDTH-1];
`else
  assign cur_bit = shreg[0];
`endif

  // Value entering stage 0 this cycle: a real bit while shifting, a bubble otherwise.
  always_comb begin
    push_v = (state == SHIFT);
    push_d = push_v & cur_bit;
    push_l = push_v & (cnt == CW'(WIDTH - 1));
  end

  assign out_done = v_chain[DEPTH-1] & l_chain[DEPTH-1];

  // Sequencer FSM: owns the state, the shifter and the pushed-bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else if (flush) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= SHIFT;
            shreg <= in_data;
            cnt   <= '0;
          end
        end
        SHIFT: begin
`ifdef MSB_FIRST_EN
          shreg <= {shreg[WIDTH-2:0], 1'b0};
`else
          shreg <= {1'b0, shreg[WIDTH-1:1]};
`endif
          cnt <= cnt + CW'(1);
          // The push happening on this edge is the last one of the word.
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Leave as soon as the last bit has been presented on the outputs.
          if (out_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Delay line: every stage copies its predecessor each cycle, stage 0 takes the push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_chain <= '0;
      v_chain <= '0;
      l_chain <= '0;
    end else if (flush) begin
      d_chain <= '0;
      v_chain <= '0;
      l_chain <= '0;
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        d_chain[k] <= d_chain[k-1];
        v_chain[k] <= v_chain[k-1];
        l_chain[k] <= l_chain[k-1];
      end
      d_chain[0] <= push_d;
      v_chain[0] <= push_v;
      l_chain[0] <= push_l;
    end
  end

  // Outputs come straight from state and the final stage; data is gated by valid.
  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
    ser_en   = v_chain[DEPTH-1];
    ser_q    = d_chain[DEPTH-1] & v_chain[DEPTH-1];
    done     = out_done;
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: two instances (DEPTH=2 and DEPTH=1) share the stimulus.
// The reference model keeps only the accepted word and its accept edge per instance
// and derives every expected output from the timing rules with plain arithmetic.
module tb_shift_seq_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         flush;

  logic o_rdy  [2];
  logic o_q    [2];
  logic o_en   [2];
  logic o_busy [2];
  logic o_done [2];

  shift_seq_ctrl #(.WIDTH(W), .DEPTH(2)) u_d2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (o_rdy[0]),
    .in_data  (in_data),
    .flush    (flush),
    .ser_q    (o_q[0]),
    .ser_en   (o_en[0]),
    .busy     (o_busy[0]),
    .done     (o_done[0])
  );

  shift_seq_ctrl #(.WIDTH(W), .DEPTH(1)) u_d1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (o_rdy[1]),
    .in_data  (in_data),
    .flush    (flush),
    .ser_q    (o_q[1]),
    .ser_en   (o_en[1]),
    .busy     (o_busy[1]),
    .done     (o_done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: word in flight and the edge number it was accepted on.
  bit           m_act  [2];
  logic [W-1:0] m_word [2];
  int           m_t0   [2];

  function automatic int dep(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic int rel(input int k, input int c);
    return c - m_t0[k] - dep(k);
  endfunction

  function automatic logic e_ready(input int k, input int c);
    return !m_act[k] || (c >= m_t0[k] + W + dep(k));
  endfunction

  function automatic logic e_en(input int k, input int c);
    return m_act[k] && (rel(k, c) >= 0) && (rel(k, c) < W);
  endfunction

  function automatic logic e_q(input int k, input int c);
    int i;
    i = rel(k, c);
    if (!e_en(k, c)) return 1'b0;
`ifdef MSB_FIRST_EN
    return m_word[k][W-1-i];
`else
    return m_word[k][i];
`endif
  endfunction

  function automatic logic e_done(input int k, input int c);
    return e_en(k, c) && (rel(k, c) == W - 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("in_ready[d%0d]", dep(k)), 32'(o_rdy[k]),  32'(e_ready(k, cyc)));
      check($sformatf("busy[d%0d]",     dep(k)), 32'(o_busy[k]), 32'(!e_ready(k, cyc)));
      check($sformatf("ser_en[d%0d]",   dep(k)), 32'(o_en[k]),   32'(e_en(k, cyc)));
      check($sformatf("ser_q[d%0d]",    dep(k)), 32'(o_q[k]),    32'(e_q(k, cyc)));
      check($sformatf("done[d%0d]",     dep(k)), 32'(o_done[k]), 32'(e_done(k, cyc)));
    end
  endtask

  // Drive one cycle of inputs, apply the edge to the model, check at the falling edge.
  task automatic tick(input logic v, input logic [W-1:0] d, input logic f);
    logic rp;
    in_valid = v;
    in_data  = d;
    flush    = f;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      rp = e_ready(k, cyc);
      if (!rst_n || f) begin
        m_act[k] = 1'b0;
      end else if (v && rp) begin
        m_act[k]  = 1'b1;
        m_word[k] = d;
        m_t0[k]   = cyc + 1;
      end
    end
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  // Reset asserted between edges; outputs must respond without any clock edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) m_act[k] = 1'b0;
    #1;
    check_outputs();
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    flush    = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_act[k]  = 1'b0;
      m_word[k] = '0;
      m_t0[k]   = 0;
    end

    // Reset state, then release away from the clock edge.
    tick(1'b0, '0, 1'b0);
    tick(1'b0, '0, 1'b0);
    rst_n = 1'b1;
    tick(1'b0, '0, 1'b0);

    // Single word 8'hC4 and full drain.
    tick(1'b1, 8'hC4, 1'b0);
    for (int i = 0; i < 12; i++) tick(1'b0, 8'h00, 1'b0);

    // in_valid held: 8'h01 first, then 8'hFF offered continuously.
    tick(1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 12; i++) tick(1'b0, 8'h00, 1'b0);

    // Flush in cycle 5 of a word.
    tick(1'b1, 8'hA5, 1'b0);
    for (int i = 1; i < 5; i++) tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 12; i++) tick(1'b0, 8'h00, 1'b0);

    // Flush and in_valid together while idle: word must be refused.
    tick(1'b1, 8'h3C, 1'b1);
    tick(1'b0, 8'h00, 1'b0);

    // Reset mid-word, then a fresh word must serialise cleanly.
    tick(1'b1, 8'h96, 1'b0);
    for (int i = 1; i < 5; i++) tick(1'b0, 8'h00, 1'b0);
    async_reset();
    tick(1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'h5B, 1'b0);
    for (int i = 0; i < 12; i++) tick(1'b0, 8'h00, 1'b0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        async_reset();
        tick(1'b0, 8'(($urandom)), 1'b0);
        rst_n = 1'b1;
      end
      tick(($urandom_range(0, 99) < 60), 8'($urandom), ($urandom_range(0, 99) < 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net against a stalled bench.
  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
